// File: rtl/mop_pkg.sv
// Shared constants, types and helpers for the pipelined multi-operand adder.
package mop_pkg;

  localparam int MOP_WIDTH   = 3;
  localparam int MOP_NUM_OPS = 3;
  localparam int MOP_ACC_W   = 8;

  // Narrowest width that holds the exact sum of num_ops operands of width bits.
  function automatic int min_result_w(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

  typedef struct packed {
    logic [MOP_NUM_OPS*MOP_WIDTH-1:0] ops;
    logic                             acc;
  } mop_beat_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_HALF,
    OCC_FULL
  } mop_occ_e;

endpackage

// File: rtl/multi_operand_adder_pipe_if.sv
// Operand-in / result-out handshake bundle for multi_operand_adder_pipe.
interface multi_operand_adder_pipe_if #(
  parameter int WIDTH   = mop_pkg::MOP_WIDTH,
  parameter int NUM_OPS = mop_pkg::MOP_NUM_OPS,
  parameter int ACC_W   = mop_pkg::MOP_ACC_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OPS*WIDTH-1:0] in_ops;
  logic                     in_acc;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_sum;
  logic                     out_carry;

  modport master (
    output in_valid, in_ops, in_acc, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_ops, in_acc, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );

endinterface

// File: rtl/mop_csa_tree.sv
// Combinational carry-save reduction of NUM_OPS unsigned operands plus a final ripple add.
module mop_csa_tree
  import mop_pkg::*;
#(
  parameter int WIDTH   = MOP_WIDTH,
  parameter int NUM_OPS = MOP_NUM_OPS,
  parameter int SUM_W   = min_result_w(WIDTH, NUM_OPS)
) (
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  output logic [SUM_W-1:0]         sum
);

  logic [SUM_W-1:0] s_vec;
  logic [SUM_W-1:0] c_vec;
  logic [SUM_W-1:0] x_vec;
  logic [SUM_W-1:0] maj;
  logic             cy;

  // All arithmetic is mod 2^SUM_W; the true total always fits, so dropped
  // carries out of the top bit are always zero in the final result.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop reads it,
    // so no path leaves a stale value behind and no latch is inferred.
    sum   = '0;
    s_vec = SUM_W'(ops[0 +: WIDTH]);
    c_vec = '0;
    x_vec = '0;
    maj   = '0;
    cy    = 1'b0;
    for (int k = 1; k < NUM_OPS; k++) begin
      x_vec = SUM_W'(ops[k*WIDTH +: WIDTH]);
      maj   = (s_vec & c_vec) | (s_vec & x_vec) | (c_vec & x_vec);
      s_vec = s_vec ^ c_vec ^ x_vec;
      c_vec = maj << 1;
    end
    for (int i = 0; i < SUM_W; i++) begin
      sum[i] = s_vec[i] ^ c_vec[i] ^ cy;
      cy     = (s_vec[i] & c_vec[i]) | (s_vec[i] & cy) | (c_vec[i] & cy);
    end
  end

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Two-stage pipelined multi-operand adder with optional running accumulation.
// Build option: define MOP_ACC_SATURATE_EN to clamp accumulate overflow instead of wrapping.
module multi_operand_adder_pipe
  import mop_pkg::*;
#(
  parameter int WIDTH   = MOP_WIDTH,
  parameter int NUM_OPS = MOP_NUM_OPS,
  parameter int ACC_W   = MOP_ACC_W
) (
  input logic                        clk,
  input logic                        rst_n,
  multi_operand_adder_pipe_if.slave  bus
);

  localparam int OPS_W = NUM_OPS * WIDTH;
  localparam int SUM_W = min_result_w(WIDTH, NUM_OPS);

  if (NUM_OPS < 2) begin : g_bad_num_ops
    $error("multi_operand_adder_pipe: NUM_OPS must be at least 2");
  end
  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("multi_operand_adder_pipe: ACC_W must be >= WIDTH + clog2(NUM_OPS)");
  end

  typedef struct packed {
    logic [OPS_W-1:0] ops;
    logic             acc;
  } beat_t;

  beat_t            s1;
  logic             s1_valid;
  logic             out_valid;
  logic             out_carry;
  logic [ACC_W-1:0] acc;
  mop_occ_e         occ;
  logic             s2_free;
  logic             advance;
  logic             accept;
  logic [SUM_W-1:0] opsum;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W-1:0] acc_next;
  logic             carry_next;
`ifdef MOP_ACC_SATURATE_EN
  logic             sat_flag;
  logic             sat_next;
`endif

  always_comb begin
    case ({s1_valid, out_valid})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_FULL;
      default: occ = OCC_HALF;
    endcase
  end

  assign s2_free      = !out_valid || bus.out_ready;
  assign advance      = s1_valid && s2_free;
  assign bus.in_ready = (occ != OCC_FULL) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the S1 payload has no reset; s1_valid alone decides whether it means anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1 <= '{ops: bus.in_ops, acc: bus.in_acc};
    end
  end

  mop_csa_tree #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .SUM_W   (SUM_W)
  ) u_csa_tree (
    .ops (s1.ops),
    .sum (opsum)
  );

  always_comb begin
    acc_wide   = {1'b0, acc} + (ACC_W+1)'(opsum);
    acc_next   = ACC_W'(opsum);
    carry_next = 1'b0;
`ifdef MOP_ACC_SATURATE_EN
    sat_next   = 1'b0;
    if (s1.acc) begin
      // Once clamped, stay clamped until a plain-sum beat restarts the total.
      if (acc_wide[ACC_W] || sat_flag) begin
        acc_next   = '1;
        carry_next = 1'b1;
        sat_next   = 1'b1;
      end else begin
        acc_next   = acc_wide[ACC_W-1:0];
      end
    end
`else
    if (s1.acc) begin
      acc_next   = acc_wide[ACC_W-1:0];
      carry_next = acc_wide[ACC_W];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_carry <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= 1'b1;
      out_carry <= carry_next;
      acc       <= acc_next;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MOP_ACC_SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (advance) begin
      sat_flag <= sat_next;
    end
  end
`endif

  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc;
  assign bus.out_carry = out_carry;

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed self-checking bench for multi_operand_adder_pipe (WIDTH=3, NUM_OPS=3, ACC_W=8).
module tb_multi_operand_adder_pipe;
  import mop_pkg::*;

  localparam int W = 3;
  localparam int N = 3;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_operand_adder_pipe_if #(.WIDTH(W), .NUM_OPS(N), .ACC_W(A)) bus ();

  multi_operand_adder_pipe #(.WIDTH(W), .NUM_OPS(N), .ACC_W(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";
  int    exp_sum_q[$];
  bit    exp_carry_q[$];
  int    m_acc;
  bit    m_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int a, input int b, input int c, input bit acc);
    mop_beat_t bt;
    bt.ops       = {3'(c), 3'(b), 3'(a)};
    bt.acc       = acc;
    bus.in_valid = 1'b1;
    bus.in_ops   = bt.ops;
    bus.in_acc   = bt.acc;
  endtask

  // Consumes the result leaving on the coming edge, then advances one cycle.
  task automatic tick();
    if (bus.out_valid && bus.out_ready) begin
      if (exp_sum_q.size() == 0) begin
        check("dup_beat", 32'(exp_sum_q.size()), 32'd1);
      end else begin
        check("out_sum", 32'(bus.out_sum), 32'(exp_sum_q.pop_front()));
        check("out_carry", 32'(bus.out_carry), 32'(exp_carry_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int a, input int b, input int c, input bit acc,
                      input int exp_sum, input bit exp_carry);
    bit accepted = 1'b0;
    set_beat(a, b, c, acc);
    #1;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (bus.in_ready) begin
        exp_sum_q.push_back(exp_sum);
        exp_carry_q.push_back(exp_carry);
        accepted = 1'b1;
      end
      tick();
    end
    if (!accepted) check("accept_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (exp_sum_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check("drain_left", 32'(exp_sum_q.size()), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int es;
    bit ec;
    int ra, rb, rc, rsum, rt;
    bit racc, accepted;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ops    = '0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'd1);
    check("out_valid", 32'(bus.out_valid), 32'd0);
    check("out_sum", 32'(bus.out_sum), 32'd0);
    check("out_carry", 32'(bus.out_carry), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    phase = "plain";
    send(7, 4, 5, 1'b0, 16, 1'b0);
    check("latency_early", 32'(bus.out_valid), 32'd0);
    send(1, 1, 1, 1'b0, 3, 1'b0);
    check("latency_two", 32'(bus.out_valid), 32'd1);
    send(0, 0, 0, 1'b0, 0, 1'b0);
    drain();

    phase = "accum";
    send(7, 7, 7, 1'b0, 21, 1'b0);
    for (int k = 2; k <= 14; k++) begin
`ifdef MOP_ACC_SATURATE_EN
      es = (k >= 13) ? 255 : 21 * k;
      ec = (k >= 13);
`else
      es = (21 * k) % 256;
      ec = (k == 13);
`endif
      send(7, 7, 7, 1'b1, es, ec);
    end
    send(1, 0, 0, 1'b0, 1, 1'b0);
    drain();

    phase = "backpressure";
    bus.out_ready = 1'b0;
    send(1, 2, 3, 1'b0, 6, 1'b0);
    send(3, 3, 1, 1'b0, 7, 1'b0);
    check("in_ready_low", 32'(bus.in_ready), 32'd0);
    set_beat(4, 0, 0, 1'b0);
    repeat (3) begin
      tick();
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.out_sum), 32'd6);
    end
    bus.out_ready = 1'b1;
    send(4, 0, 0, 1'b0, 4, 1'b0);
    send(5, 5, 5, 1'b0, 15, 1'b0);
    drain();

    phase = "reset_mid";
    bus.out_ready = 1'b0;
    send(1, 1, 1, 1'b0, 3, 1'b0);
    send(2, 0, 0, 1'b0, 2, 1'b0);
    check("full_sum", 32'(bus.out_sum), 32'd3);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    exp_sum_q.delete();
    exp_carry_q.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(1, 2, 3, 1'b1, 6, 1'b0);
    drain();

    phase = "random";
    m_acc = 6;
    m_sat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ra   = int'($urandom_range(0, 7));
      rb   = int'($urandom_range(0, 7));
      rc   = int'($urandom_range(0, 7));
      racc = 1'($urandom_range(0, 1));
      set_beat(ra, rb, rc, racc);
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (bus.in_ready) begin
          rsum = ra + rb + rc;
          if (!racc) begin
            m_acc = rsum;
            ec    = 1'b0;
            m_sat = 1'b0;
          end else begin
            rt = m_acc + rsum;
`ifdef MOP_ACC_SATURATE_EN
            if (rt > 255 || m_sat) begin
              m_acc = 255;
              ec    = 1'b1;
              m_sat = 1'b1;
            end else begin
              m_acc = rt;
              ec    = 1'b0;
            end
`else
            ec    = (rt > 255);
            m_acc = rt % 256;
`endif
          end
          exp_sum_q.push_back(m_acc);
          exp_carry_q.push_back(ec);
          accepted = 1'b1;
        end
        tick();
      end
      if (!accepted) check("rand_accept_timeout", 32'(bus.in_ready), 32'd1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
